mem_access_unit: RTL and testbench

- Load/store alignment unit between the execute stage and a 32-bit, word-addressed, byte-strobed data bus.
- Converts a byte-addressed load/store request (op, size/sign select, address, store data) into bus read-enable, byte write strobes, word address and lane-positioned write data.
- Extracts and sign/zero-extends load data returned by a synchronous bus one cycle after the request.

---
 rtl/mem_access_unit_pkg.sv | 27 ++
 rtl/mem_access_unit_load_extend.sv | 50 +++++
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store path.
//   MEM_OP_*  : operation codes carried on mem_op (2'd3 reserved, acts as NONE)
//   MEM_SEL_* : access size/sign codes carried on mem_sel (3'd3, 3'd6, 3'd7 reserved)
// Used by the instruction decoder, mem_access_unit and the benches.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [2:0] MEM_SEL_B  = 3'd0;
  localparam logic [2:0] MEM_SEL_H  = 3'd1;
  localparam logic [2:0] MEM_SEL_W  = 3'd2;
  localparam logic [2:0] MEM_SEL_BU = 3'd4;
  localparam logic [2:0] MEM_SEL_HU = 3'd5;

  // Low two bits of a legal select give the access size:
  // 0 = byte, 1 = halfword, 2 = word. Bit 2 only marks "unsigned".
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic sel_reserved(input logic [2:0] sel);
    return (sel == 3'd3) || (sel == 3'd6) || (sel == 3'd7);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load-data extraction.
//   sel   : access size/sign of the load being returned
//   off   : byte offset of that load within the bus word
//   rdata : raw word from the bus
//   ext   : selected byte/halfword/word, sign- or zero-extended
// Reserved selects return zero.
module mem_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  function automatic logic signed [31:0] sext_byte(input logic signed [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic signed [31:0] sext_half(input logic signed [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  logic signed [7:0]  lane_byte;
  logic signed [15:0] lane_half;

  always_comb begin
    lane_byte = '0;
    case (off)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext = '0;
    case (sel)
      MEM_SEL_B:  ext = sext_byte(lane_byte);
      MEM_SEL_BU: ext = {24'h0, lane_byte};
      MEM_SEL_H:  ext = sext_half(lane_half);
      MEM_SEL_HU: ext = {16'h0, lane_half};
      MEM_SEL_W:  ext = rdata;
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store alignment unit between execute and a 32-bit word-addressed,
// byte-strobed synchronous data bus.
//   clk, rst_n      : clock, synchronous active-low reset
//   mem_op/mem_sel  : operation and access size/sign of the request
//   mem_addr        : byte address; mem_wdata : right-justified store data
//   mem_rdata       : extended load result, valid one cycle after the load
//   mem_misaligned  : current request is illegal or uses a reserved select
//   bus_re/bus_we   : read enable / per-lane write strobes (same cycle)
//   bus_addr        : word-aligned address; bus_wdata : lane-replicated data
//   bus_rdata       : bus read data, returned the cycle after bus_re
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mem_op,
  input  logic [2:0]      mem_sel,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_misaligned,
  output logic            bus_re,
  output logic [3:0]      bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata
);

  logic [1:0] off_p0;
  logic [1:0] size_p0;
  logic       is_load_p0;
  logic       is_store_p0;
  logic       legal_p0;

  logic       load_pend_p1;
  logic [2:0] sel_p1;
  logic [1:0] off_p1;
  logic [31:0] ext_p1;

  // ---- Stage p0: combinational request decode ----
  assign off_p0      = mem_addr[1:0];
  assign size_p0     = mem_sel[1:0];
  assign is_load_p0  = (mem_op == MEM_OP_LOAD);
  assign is_store_p0 = (mem_op == MEM_OP_STORE);
  assign bus_addr    = {mem_addr[XLEN-1:2], 2'b00};

  always_comb begin
    legal_p0 = 1'b0;
    if (!sel_reserved(mem_sel)) begin
      case (size_p0)
        SIZE_BYTE: legal_p0 = 1'b1;
        SIZE_HALF: legal_p0 = ~off_p0[0];
        SIZE_WORD: legal_p0 = (off_p0 == 2'd0);
        default:   legal_p0 = 1'b0;
      endcase
    end
  end

  // Reserved op 2'd3 decodes as neither load nor store, so it is silent.
  assign mem_misaligned = (is_load_p0 || is_store_p0) && !legal_p0;
  assign bus_re         = is_load_p0 && legal_p0;

  always_comb begin
    bus_we    = 4'b0000;
    bus_wdata = '0;
    if (is_store_p0 && legal_p0) begin
      // Unsigned selects share size bits with their signed twins, so a
      // BU/HU store lands here as a plain byte/halfword store.
      case (size_p0)
        SIZE_BYTE: begin
          bus_we    = 4'b0001 << off_p0;
          bus_wdata = {4{mem_wdata[7:0]}};
        end
        SIZE_HALF: begin
          bus_we    = 4'b0011 << off_p0;
          bus_wdata = {2{mem_wdata[15:0]}};
        end
        default: begin
          bus_we    = 4'b1111;
          bus_wdata = mem_wdata;
        end
      endcase
    end
  end

  // ---- Stage p1: load response, bus data arrives this cycle ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_pend_p1 <= 1'b0;
      sel_p1       <= 3'd0;
      off_p1       <= 2'd0;
    end else begin
      load_pend_p1 <= bus_re;
      sel_p1       <= mem_sel;
      off_p1       <= off_p0;
    end
  end

  mem_load_extend u_load_extend (
    .sel   (sel_p1),
    .off   (off_p1),
    .rdata (bus_rdata),
    .ext   (ext_p1)
  );

  assign mem_rdata = load_pend_p1 ? ext_p1 : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_op;
  logic [2:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_misaligned;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  mem_access_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_op         (mem_op),
    .mem_sel        (mem_sel),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_misaligned (mem_misaligned),
    .bus_re         (bus_re),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive request and the bus response for the previous
  // cycle, check same-cycle outputs, compare mem_rdata against the
  // scoreboard, then queue what the next cycle must return.
  task automatic step(input string name, input logic rst_val,
                      input logic [1:0] op, input logic [2:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] brd,
                      input logic e_re, input logic [3:0] e_we,
                      input logic [31:0] e_wdata, input logic e_mis,
                      input logic [31:0] e_next_rdata);
    logic [31:0] e_rd;
    rst_n     = rst_val;
    mem_op    = op;
    mem_sel   = sel;
    mem_addr  = addr;
    mem_wdata = wdata;
    bus_rdata = brd;
    #1;
    chk({name, ".bus_re"},    {31'h0, bus_re},         {31'h0, e_re});
    chk({name, ".bus_we"},    {28'h0, bus_we},         {28'h0, e_we});
    chk({name, ".bus_addr"},  bus_addr,                {addr[31:2], 2'b00});
    chk({name, ".bus_wdata"}, bus_wdata,               e_wdata);
    chk({name, ".misalign"},  {31'h0, mem_misaligned}, {31'h0, e_mis});
    if (exp_q.size() > 0) begin
      e_rd = exp_q.pop_front();
      chk({name, ".mem_rdata"}, mem_rdata, e_rd);
    end
    exp_q.push_back(e_next_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_op = MEM_OP_NONE; mem_sel = MEM_SEL_B;
    mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
    @(posedge clk); #1;

    //   name       rst  op            sel         addr          wdata         bus_rdata     re  we       wdata         mis next_rdata
    step("rst_idle", 0, MEM_OP_NONE,  MEM_SEL_W,  32'h0000_0000, 32'h1111_1111, 32'h0,        0, 4'b0000, 32'h0,        0, 32'h0);
    step("rst_ld",   0, MEM_OP_LOAD,  MEM_SEL_B,  32'h0000_0202, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'h0);
    step("st_w",     1, MEM_OP_STORE, MEM_SEL_W,  32'h0000_0100, 32'hDEADBEEF, 32'h12805634, 0, 4'b1111, 32'hDEADBEEF, 0, 32'h0);
    step("st_b",     1, MEM_OP_STORE, MEM_SEL_B,  32'h0000_0103, 32'h0000_00A5, 32'h0,       0, 4'b1000, 32'hA5A5A5A5, 0, 32'h0);
    step("ld_b",     1, MEM_OP_LOAD,  MEM_SEL_B,  32'h0000_0202, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'hFFFFFF80);
    step("ld_bu",    1, MEM_OP_LOAD,  MEM_SEL_BU, 32'h0000_0202, 32'h0,        32'h12805634, 1, 4'b0000, 32'h0,        0, 32'h00000080);
    step("ld_h",     1, MEM_OP_LOAD,  MEM_SEL_H,  32'h0000_0002, 32'h0,        32'h12805634, 1, 4'b0000, 32'h0,        0, 32'hFFFF8001);
    step("ld_hu",    1, MEM_OP_LOAD,  MEM_SEL_HU, 32'h0000_0002, 32'h0,        32'h8001ABCD, 1, 4'b0000, 32'h0,        0, 32'h00008001);
    step("ld_w",     1, MEM_OP_LOAD,  MEM_SEL_W,  32'h0000_0100, 32'h0,        32'h8001ABCD, 1, 4'b0000, 32'h0,        0, 32'h13579BDF);
    step("st_h",     1, MEM_OP_STORE, MEM_SEL_H,  32'h0000_0102, 32'h1234BEEF, 32'h13579BDF, 0, 4'b1100, 32'hBEEFBEEF, 0, 32'h0);
    step("ld_w_mis", 1, MEM_OP_LOAD,  MEM_SEL_W,  32'h0000_0101, 32'h0,        32'hFFFFFFFF, 0, 4'b0000, 32'h0,        1, 32'h0);
    step("st_h_mis", 1, MEM_OP_STORE, MEM_SEL_H,  32'h0000_0103, 32'h0000_1234, 32'hFFFFFFFF, 0, 4'b0000, 32'h0,       1, 32'h0);
    step("ld_bu3",   1, MEM_OP_LOAD,  MEM_SEL_BU, 32'h0000_0003, 32'h0,        32'hFFFFFFFF, 1, 4'b0000, 32'h0,        0, 32'h000000A1);
    step("ld_rsv",   1, MEM_OP_LOAD,  3'd3,       32'h0000_0000, 32'h0,        32'hA1B2C3D4, 0, 4'b0000, 32'h0,        1, 32'h0);
    step("op_rsv",   1, 2'd3,         MEM_SEL_W,  32'h0000_0040, 32'h5555AAAA, 32'hA1B2C3D4, 0, 4'b0000, 32'h0,        0, 32'h0);
    step("ld_hu2",   1, MEM_OP_LOAD,  MEM_SEL_HU, 32'h0000_0202, 32'h0,        32'h0BADF00D, 1, 4'b0000, 32'h0,        0, 32'h0000CAFE);
    step("ld_h0",    1, MEM_OP_LOAD,  MEM_SEL_H,  32'h0000_0000, 32'h0,        32'hCAFE1234, 1, 4'b0000, 32'h0,        0, 32'h00007FFF);
    step("ld_rst",   0, MEM_OP_LOAD,  MEM_SEL_W,  32'h0000_0000, 32'h0,        32'h00007FFF, 1, 4'b0000, 32'h0,        0, 32'h0);
    step("idle1",    1, MEM_OP_NONE,  MEM_SEL_B,  32'h0000_0000, 32'h0,        32'hFFFFFFFF, 0, 4'b0000, 32'h0,        0, 32'h0);
    step("st_bu",    1, MEM_OP_STORE, MEM_SEL_BU, 32'h0000_0101, 32'h0000_005A, 32'hFFFFFFFF, 0, 4'b0010, 32'h5A5A5A5A, 0, 32'h0);
    step("st_hu",    1, MEM_OP_STORE, MEM_SEL_HU, 32'h0000_0100, 32'hFFFF0000, 32'hFFFFFFFF, 0, 4'b0011, 32'h0,        0, 32'h0);
    step("idle2",    1, MEM_OP_NONE,  MEM_SEL_W,  32'h0000_0000, 32'h0,        32'hFFFFFFFF, 0, 4'b0000, 32'h0,        0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
